seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter SIZE, default 4, operand/result width in bits; legal range 2..32.
REQ-002 i_CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 i_RST_N  input  1  reset, asynchronous, active-low.
REQ-004 i_START  input  1  request; sampled only while o_BUSY=0.
REQ-005 i_A  input  SIZE  unsigned dividend; sampled with an accepted i_START.
REQ-006 i_B  input  SIZE  unsigned divisor; sampled with an accepted i_START.
REQ-007 o_Q  output  SIZE  quotient, registered.
REQ-008 o_R  output  SIZE  remainder, registered.
REQ-009 o_BUSY  output  1  high while a division is in progress.
REQ-010 o_DONE  output  1  one-cycle pulse marking valid o_Q/o_R.
REQ-011 o_DBZ  output  1  divide-by-zero flag; present only under DIVIDER_DBZ_FLAG_EN.

Function
REQ-012 The block SHALL perform unsigned restoring division, one quotient bit per clock, MSB first: shift {rem, dividend} left 1, trial-subtract divisor from SIZE+1-bit partial remainder, keep the result and set the quotient bit if non-negative.
REQ-013 The FSM SHALL have states IDLE, CALC, DONE: IDLE->CALC on i_START; CALC->DONE after exactly SIZE iterations; DONE->IDLE (or DONE->CALC on i_START) after one cycle.
REQ-014 Start accepted at edge 0 SHALL latch i_A/i_B, load an iteration counter with SIZE, and set o_BUSY=1 after edge 0.
REQ-015 Iterations SHALL occur at edges 1..SIZE; o_Q/o_R SHALL update and o_DONE=1, o_BUSY=0 after edge SIZE (latency SIZE cycles from start edge to o_DONE).
REQ-016 o_DONE SHALL be high for exactly one cycle per accepted start.
REQ-017 o_Q/o_R SHALL hold their last values from o_DONE until the next o_DONE; they SHALL not change during CALC.
REQ-018 i_START while o_BUSY=1 SHALL be ignored; i_A/i_B changes during CALC SHALL not affect the result.
REQ-019 i_START in the DONE cycle SHALL be accepted (back-to-back operation, no idle gap).
REQ-020 Divisor zero SHALL yield o_Q = all ones and o_R = i_A, with standard latency.
REQ-021 Results SHALL satisfy A = Q*B + R and R < B for every B != 0, all SIZE.

Reset
REQ-022 i_RST_N=0 SHALL immediately, independent of i_CLK, force FSM=IDLE, counter=0, o_Q=0, o_R=0, o_BUSY=0, o_DONE=0, o_DBZ=0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation; no o_DONE SHALL follow for it.
REQ-024 After deassertion the first i_START SHALL be accepted on the first rising edge.

Configuration
REQ-025 Macro DIVIDER_DBZ_FLAG_EN defined: o_DBZ exists, registered with o_Q/o_R, =1 when the latched divisor is zero, held until next o_DONE.
REQ-026 Macro DIVIDER_DBZ_FLAG_EN undefined: o_DBZ port and its logic absent; all other behaviour identical.

Verification (SIZE=4)
REQ-027 A=13, B=3, start at edge 0 -> o_DONE pulse after edge 4 only, o_Q=4, o_R=1, o_BUSY high after edges 0..3.
REQ-028 A=15, B=1 then A=0, B=5 back-to-back (start in DONE cycle) -> Q=15,R=0 then Q=0,R=0, two o_DONE pulses 5 cycles apart.
REQ-029 A=7, B=0 -> o_Q=15, o_R=7, o_DBZ=1 with macro; same Q/R without.
REQ-030 A=9, B=2 started; i_START with A=14, B=7 at edge 2 -> ignored, result Q=4, R=1, single o_DONE.
REQ-031 Reset asserted at edge 2 of A=11, B=3 -> all outputs 0 immediately, no o_DONE; new A=11, B=3 after release -> Q=3, R=2.
REQ-032 Exhaustive sweep of all 256 (A,B) pairs -> every result matches A/B and A%B (B=0 per REQ-020).

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential restoring divider.
// The master side issues a start with operands; the slave side (the divider)
// returns quotient, remainder, busy and a one-cycle done pulse.
// Optional divide-by-zero flag o_DBZ exists only when DIVIDER_DBZ_FLAG_EN is defined.
interface seq_divider_if #(
   parameter int SIZE = 4
);

   logic            i_START;
   logic [SIZE-1:0] i_A;
   logic [SIZE-1:0] i_B;
   logic [SIZE-1:0] o_Q;
   logic [SIZE-1:0] o_R;
   logic            o_BUSY;
   logic            o_DONE;
`ifdef DIVIDER_DBZ_FLAG_EN
   logic            o_DBZ;

   modport master (
      output i_START, i_A, i_B,
      input  o_Q, o_R, o_BUSY, o_DONE, o_DBZ
   );

   modport slave (
      input  i_START, i_A, i_B,
      output o_Q, o_R, o_BUSY, o_DONE, o_DBZ
   );
`else
   modport master (
      output i_START, i_A, i_B,
      input  o_Q, o_R, o_BUSY, o_DONE
   );

   modport slave (
      input  i_START, i_A, i_B,
      output o_Q, o_R, o_BUSY, o_DONE
   );
`endif

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// A start in IDLE or DONE latches the operands; SIZE iterations later the
// registered quotient/remainder update together with a one-cycle done pulse.
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
// Optional feature: define DIVIDER_DBZ_FLAG_EN to add the o_DBZ result flag.
module seq_divider #(
   parameter int SIZE = 4
) (
   input  logic         i_CLK,
   input  logic         i_RST_N,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(SIZE + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic [CW-1:0]   count_q,    count_d;
   logic [SIZE-1:0] divisor_q,  divisor_d;
   logic [SIZE-1:0] dividend_q, dividend_d;
   logic [SIZE-1:0] rem_q,      rem_d;
   logic [SIZE-1:0] quoOut_q,   quoOut_d;
   logic [SIZE-1:0] remOut_q,   remOut_d;
`ifdef DIVIDER_DBZ_FLAG_EN
   logic            dbz_q,      dbz_d;
`endif

   logic [SIZE:0]   shifted;
   logic            fits;
   logic [SIZE-1:0] stepRem;
   logic [SIZE-1:0] stepQuo;

   // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract
   always_comb begin
      shifted = {rem_q, dividend_q[SIZE-1]};
      fits    = (shifted >= {1'b0, divisor_q});
      stepRem = fits ? SIZE'(shifted - {1'b0, divisor_q}) : shifted[SIZE-1:0];
      stepQuo = {dividend_q[SIZE-2:0], fits};
   end

   // Next-state and datapath control: accept starts outside CALC, iterate SIZE times, then publish
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      divisor_d  = divisor_q;
      dividend_d = dividend_q;
      rem_d      = rem_q;
      quoOut_d   = quoOut_q;
      remOut_d   = remOut_q;
`ifdef DIVIDER_DBZ_FLAG_EN
      dbz_d      = dbz_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (bus.i_START) begin
               state_d    = CALC;
               count_d    = CW'(SIZE);
               divisor_d  = bus.i_B;
               dividend_d = bus.i_A;
               rem_d      = '0;
            end else begin
               state_d    = IDLE;
            end
         end
         CALC: begin
            rem_d      = stepRem;
            dividend_d = stepQuo;
            count_d    = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d  = DONE;
               quoOut_d = stepQuo;
               remOut_d = stepRem;
`ifdef DIVIDER_DBZ_FLAG_EN
               dbz_d    = (divisor_q == '0);
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, working registers and published results; reset clears everything at once
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q    <= IDLE;
         count_q    <= '0;
         divisor_q  <= '0;
         dividend_q <= '0;
         rem_q      <= '0;
         quoOut_q   <= '0;
         remOut_q   <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
         dbz_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         divisor_q  <= divisor_d;
         dividend_q <= dividend_d;
         rem_q      <= rem_d;
         quoOut_q   <= quoOut_d;
         remOut_q   <= remOut_d;
`ifdef DIVIDER_DBZ_FLAG_EN
         dbz_q      <= dbz_d;
`endif
      end
   end

   assign bus.o_Q    = quoOut_q;
   assign bus.o_R    = remOut_q;
   assign bus.o_BUSY = (state_q == CALC);
   assign bus.o_DONE = (state_q == DONE);
`ifdef DIVIDER_DBZ_FLAG_EN
   assign bus.o_DBZ  = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (SIZE=4): reset behaviour, a table of
// directed vectors, back-to-back starts, ignored starts while busy, reset
// mid-calculation, randomized operations with input noise during CALC, and
// an exhaustive sweep of all operand pairs against an arithmetic model.
module tb_seq_divider;

   localparam int SIZE = 4;
   localparam int MAXV = (1 << SIZE) - 1;

   typedef struct {
      int a;
      int b;
      int expQ;
      int expR;
   } vector_t;

   logic clk = 1'b0;
   logic rstN;
   int   checkCount = 0;
   int   passCount  = 0;

   logic [SIZE-1:0] prevQ;
   logic [SIZE-1:0] prevR;
`ifdef DIVIDER_DBZ_FLAG_EN
   logic            prevDbz;
`endif

   seq_divider_if #(.SIZE(SIZE)) divBus ();

   seq_divider #(.SIZE(SIZE)) dut (
      .i_CLK   (clk),
      .i_RST_N (rstN),
      .bus     (divBus.slave)
   );

   // Free-running clock, 10 ns period
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int modelQ(input int a, input int b);
      if (b == 0) return MAXV;
      return a / b;
   endfunction

   function automatic int modelR(input int a, input int b);
      if (b == 0) return a;
      return a % b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [SIZE-1:0] actual,
                              input logic [SIZE-1:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic checkFlag(input string name, input logic actual, input logic expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
   endtask

   // noise: 0 = quiet inputs during CALC, 1 = random start/operands, 2 = start 14/7 one cycle after edge 1
   task automatic applyStimulus(input int a, input int b, input int expQ, input int expR,
                                input int noise);
      divBus.i_START = 1'b1;
      divBus.i_A     = SIZE'(a);
      divBus.i_B     = SIZE'(b);
      tick();
      divBus.i_START = 1'b0;
      for (int c = 0; c < SIZE; c++) begin
         checkFlag("busyDuringCalc", divBus.o_BUSY, 1'b1);
         checkFlag("doneLowDuringCalc", divBus.o_DONE, 1'b0);
         checkOutput("qHoldDuringCalc", divBus.o_Q, prevQ);
         checkOutput("rHoldDuringCalc", divBus.o_R, prevR);
`ifdef DIVIDER_DBZ_FLAG_EN
         checkFlag("dbzHoldDuringCalc", divBus.o_DBZ, prevDbz);
`endif
         if (noise == 1) begin
            divBus.i_START = 1'($urandom_range(0, 1));
            divBus.i_A     = SIZE'($urandom);
            divBus.i_B     = SIZE'($urandom);
         end else if (noise == 2) begin
            divBus.i_START = (c == 1);
            divBus.i_A     = (c == 1) ? SIZE'(14) : SIZE'(a);
            divBus.i_B     = (c == 1) ? SIZE'(7)  : SIZE'(b);
         end
         tick();
      end
      divBus.i_START = 1'b0;
      checkFlag("doneAtLatency", divBus.o_DONE, 1'b1);
      checkFlag("busyLowAtDone", divBus.o_BUSY, 1'b0);
      checkOutput("quotient", divBus.o_Q, SIZE'(expQ));
      checkOutput("remainder", divBus.o_R, SIZE'(expR));
      prevQ = SIZE'(expQ);
      prevR = SIZE'(expR);
`ifdef DIVIDER_DBZ_FLAG_EN
      checkFlag("dbzFlag", divBus.o_DBZ, (b == 0));
      prevDbz = (b == 0);
`endif
   endtask

   task automatic checkIdleCycle();
      checkFlag("doneSinglePulse", divBus.o_DONE, 1'b0);
      checkFlag("busyIdle", divBus.o_BUSY, 1'b0);
      checkOutput("qHoldIdle", divBus.o_Q, prevQ);
      checkOutput("rHoldIdle", divBus.o_R, prevR);
   endtask

   task automatic checkResetOutputs();
      checkOutput("resetQ", divBus.o_Q, '0);
      checkOutput("resetR", divBus.o_R, '0);
      checkFlag("resetBusy", divBus.o_BUSY, 1'b0);
      checkFlag("resetDone", divBus.o_DONE, 1'b0);
`ifdef DIVIDER_DBZ_FLAG_EN
      checkFlag("resetDbz", divBus.o_DBZ, 1'b0);
      prevDbz = 1'b0;
`endif
      prevQ = '0;
      prevR = '0;
   endtask

   initial begin
      vector_t vectors[$];
      int ra;
      int rb;

      vectors.push_back('{a: 13, b: 3,  expQ: 4,  expR: 1});
      vectors.push_back('{a: 15, b: 1,  expQ: 15, expR: 0});
      vectors.push_back('{a: 0,  b: 5,  expQ: 0,  expR: 0});
      vectors.push_back('{a: 7,  b: 0,  expQ: 15, expR: 7});
      vectors.push_back('{a: 9,  b: 2,  expQ: 4,  expR: 1});
      vectors.push_back('{a: 11, b: 3,  expQ: 3,  expR: 2});
      vectors.push_back('{a: 15, b: 15, expQ: 1,  expR: 0});
      vectors.push_back('{a: 1,  b: 15, expQ: 0,  expR: 1});
      vectors.push_back('{a: 0,  b: 0,  expQ: 15, expR: 0});
      vectors.push_back('{a: 14, b: 4,  expQ: 3,  expR: 2});

      // Reset state
      divBus.i_START = 1'b0;
      divBus.i_A     = '0;
      divBus.i_B     = '0;
      rstN           = 1'b0;
      tick();
      tick();
      checkResetOutputs();
      rstN = 1'b1;

      // First start right after release is accepted on the first edge
      applyStimulus(13, 3, 4, 1, 0);
      tick();
      checkIdleCycle();

      // Directed table
      foreach (vectors[i]) begin
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].expQ, vectors[i].expR, 0);
         tick();
         checkIdleCycle();
      end

      // Back-to-back: second start issued in the DONE cycle
      applyStimulus(15, 1, 15, 0, 0);
      applyStimulus(0, 5, 0, 0, 0);
      tick();
      checkIdleCycle();

      // Start while busy is ignored
      applyStimulus(9, 2, 4, 1, 2);
      tick();
      checkIdleCycle();
      tick();
      checkIdleCycle();

      // Reset in the middle of a calculation (previous results are nonzero)
      applyStimulus(7, 2, 3, 1, 0);
      divBus.i_START = 1'b1;
      divBus.i_A     = SIZE'(11);
      divBus.i_B     = SIZE'(3);
      tick();
      divBus.i_START = 1'b0;
      tick();
      #2;
      rstN = 1'b0;
      #1;
      checkResetOutputs();
      tick();
      tick();
      rstN = 1'b1;
      for (int c = 0; c < SIZE + 2; c++) begin
         checkFlag("noDoneAfterAbort", divBus.o_DONE, 1'b0);
         checkFlag("noBusyAfterAbort", divBus.o_BUSY, 1'b0);
         tick();
      end
      applyStimulus(11, 3, 3, 2, 0);
      tick();
      checkIdleCycle();

      // Randomized operations with noisy inputs during CALC
      for (int n = 0; n < 40; n++) begin
         ra = int'($urandom_range(0, MAXV));
         rb = int'($urandom_range(0, MAXV));
         if (n % 8 == 0) rb = 0;
         applyStimulus(ra, rb, modelQ(ra, rb), modelR(ra, rb), 1);
         if (n % 2 == 0) begin
            tick();
            checkIdleCycle();
         end
      end
      tick();

      // Exhaustive sweep, issued back-to-back
      for (int a = 0; a <= MAXV; a++) begin
         for (int b = 0; b <= MAXV; b++) begin
            applyStimulus(a, b, modelQ(a, b), modelR(a, b), 0);
         end
      end
      tick();
      checkIdleCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
